key_report_uart: RTL



---
 rtl/key_report_pkg.sv | 19 +
 rtl/key_report_uart_tx_byte.sv | 68 ++++++
 rtl/key_report_uart.sv | 99 +++++++++
 3 files changed

// File: rtl/key_report_pkg.sv
// key_report_pkg: shared states, ASCII constants and frame layout for the key report UART.
package key_report_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, START, DATA, STOP, FIN} state_e;

    localparam logic [7:0] COLON = 8'h3A;
    localparam logic [7:0] BANG  = 8'h21;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;

    localparam int KEY_CHARS = 6;
    localparam int HDR_LEN   = 7;
    localparam int MISS_LEN  = 9;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/key_report_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer; one start, eight data bits LSB first, one stop bit.
module uart_tx_byte
    import key_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       byte_done_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_e state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic tx_q, tx_d;
    logic last;

    assign last = baud_q == BAUD_LAST;

    always_comb begin
        state_d = state_q;
        baud_d = (state_q == IDLE || last) ? '0 : baud_q + BW'(1);
        bit_d = bit_q;
        sh_d = sh_q;
        case (state_q)
            IDLE: if (load_i) begin
                state_d = START;
                sh_d = data_i;
            end
            START: if (last) state_d = DATA;
            DATA: if (last) begin
                sh_d = sh_q >> 1;
                bit_d = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            sh_q <= '0;
            tx_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            sh_q <= sh_d;
            tx_q <= tx_d;
        end
    end

    assign tx_o = tx_q;
    assign byte_done_o = state_q == STOP && last;

endmodule

// File: rtl/key_report_uart.sv
// key_report_uart: streams the found key as hex plus the decrypted message over UART.
module key_report_uart
    import key_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MSG_LEN = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       found,
    input  logic [23:0]                secret,
    input  logic [7:0]                 ram_q,
    output logic [$clog2(MSG_LEN)-1:0] ram_address,
    output logic                       tx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(MSG_LEN);
    localparam logic [5:0] LAST_HIT = 6'(HDR_LEN + MSG_LEN + 1);
    localparam logic [5:0] LAST_MISS = 6'(MISS_LEN - 1);

    state_e state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [23:0] secret_q, secret_d;
    logic found_q, found_d;
    logic [AW-1:0] addr_q;
    logic done_q;
    logic [5:0] last_idx;
    logic in_msg;
    logic [3:0] nib;
    logic [7:0] data;
    logic byte_done;

    assign last_idx = found_q ? LAST_HIT : LAST_MISS;
    assign in_msg = found_q && idx_q >= 6'(HDR_LEN) && idx_q < 6'(HDR_LEN + MSG_LEN);
    assign nib = 4'(secret_q >> (5'd20 - {idx_q[2:0], 2'b00}));
    // Byte order: key hex, separator, message (hit only), CR, LF
    assign data = idx_q < 6'(KEY_CHARS) ? hex_ascii(nib)
                : idx_q == 6'(KEY_CHARS) ? (found_q ? COLON : BANG)
                : in_msg ? ram_q
                : idx_q == last_idx ? LF : CR;
    assign ram_address = (state_q == LOAD && in_msg) ? idx_q[AW-1:0] - AW'(HDR_LEN) : addr_q;

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        secret_d = secret_q;
        found_d = found_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                idx_d = '0;
                secret_d = secret;
                found_d = found;
            end
            LOAD: state_d = FETCH;
            FETCH: state_d = START;
            START: if (byte_done) begin
                state_d = (idx_q == last_idx) ? FIN : LOAD;
                idx_d = (idx_q == last_idx) ? idx_q : idx_q + 6'd1;
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            secret_q <= '0;
            found_q <= 1'b0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            secret_q <= secret_d;
            found_q <= found_d;
            addr_q <= ram_address;
            done_q <= state_q == FIN;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk(clk),
        .reset(reset),
        .load_i(state_q == FETCH),
        .data_i(data),
        .tx_o(tx),
        .byte_done_o(byte_done)
    );

    assign busy = state_q != IDLE;
    assign done = done_q;

endmodule
